// File: rtl/pkt_buf_rd_arbiter.sv
// Two-requester read-port arbiter for the packet buffer: round-robin at burst
// granularity, with an in-order tag FIFO that steers returned flits back to their issuer.
module pkt_buf_rd_arbiter #(
    parameter int ADDR_WIDTH      = 12,
    parameter int DATA_WIDTH      = 520,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   req0_valid,
    input  logic [ADDR_WIDTH-1:0]                  req0_addr,
    input  logic                                   req0_last,
    output logic                                   req0_ready,
    input  logic                                   req1_valid,
    input  logic [ADDR_WIDTH-1:0]                  req1_addr,
    input  logic                                   req1_last,
    output logic                                   req1_ready,
    output logic                                   rd_valid,
    output logic [ADDR_WIDTH-1:0]                  rd_addr,
    input  logic                                   rd_resp_valid,
    input  logic [DATA_WIDTH-1:0]                  rd_resp_data,
    output logic                                   resp0_valid,
    output logic [DATA_WIDTH-1:0]                  resp0_data,
    output logic                                   resp1_valid,
    output logic [DATA_WIDTH-1:0]                  resp1_data,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
    output logic                                   err_orphan_resp,
    output logic [31:0]                            stats_grant0,
    output logic [31:0]                            stats_grant1
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t                     state;
    logic                       prio;
    logic [MAX_OUTSTANDING-1:0] tag_mem;
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;

    logic                       gnt;
    logic                       any_valid;
    logic                       can_issue;
    logic                       issue_p0;
    logic                       sel_last;
    logic [ADDR_WIDTH-1:0]      sel_addr;
    logic                       pop_p0;
    logic                       orphan_p0;

    logic [1:0]                 resp_vld_p1;
    logic [DATA_WIDTH-1:0]      resp_data_p1;

    // Stage 0: grant selection and zero-latency issue
    always_comb begin
        gnt       = 1'b0;
        any_valid = 1'b0;
        case (state)
            IDLE: begin
                any_valid = req0_valid | req1_valid;
                gnt       = (req0_valid && req1_valid) ? prio : req1_valid;
            end
            LOCK0: begin
                any_valid = req0_valid;
                gnt       = 1'b0;
            end
            LOCK1: begin
                any_valid = req1_valid;
                gnt       = 1'b1;
            end
            default: begin
                any_valid = 1'b0;
                gnt       = 1'b0;
            end
        endcase
    end

    // A response in this cycle frees its slot for an issue in the same cycle.
    assign can_issue = (outstanding < CNT_W'(MAX_OUTSTANDING)) || rd_resp_valid;
    // Gating with rst_n keeps the combinational outputs low while reset is held.
    assign issue_p0  = rst_n && any_valid && can_issue;
    assign sel_addr  = gnt ? req1_addr : req0_addr;
    assign sel_last  = gnt ? req1_last : req0_last;

    assign req0_ready = issue_p0 && !gnt;
    assign req1_ready = issue_p0 && gnt;
    assign rd_valid   = issue_p0;
    assign rd_addr    = issue_p0 ? sel_addr : '0;

    assign pop_p0    = rd_resp_valid && (outstanding != '0);
    assign orphan_p0 = rd_resp_valid && (outstanding == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            prio            <= 1'b0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            outstanding     <= '0;
            err_orphan_resp <= 1'b0;
            stats_grant0    <= 32'd0;
            stats_grant1    <= 32'd0;
        end else begin
            if (issue_p0) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (sel_last) begin
                    state <= IDLE;
                    prio  <= ~gnt;
                    if (gnt) stats_grant1 <= stats_grant1 + 32'd1;
                    else     stats_grant0 <= stats_grant0 + 32'd1;
                end else begin
                    state <= gnt ? LOCK1 : LOCK0;
                end
            end
            if (pop_p0)
                rd_ptr <= rd_ptr + 1'b1;
            case ({issue_p0, pop_p0})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            if (orphan_p0)
                err_orphan_resp <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (issue_p0)
            tag_mem[wr_ptr] <= gnt;
    end

    // Stage 1: registered response routing by popped tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_vld_p1  <= 2'b00;
            resp_data_p1 <= '0;
        end else begin
            resp_vld_p1[0] <= pop_p0 && !tag_mem[rd_ptr];
            resp_vld_p1[1] <= pop_p0 && tag_mem[rd_ptr];
            if (pop_p0)
                resp_data_p1 <= rd_resp_data;
        end
    end

    assign resp0_valid = resp_vld_p1[0];
    assign resp1_valid = resp_vld_p1[1];
    assign resp0_data  = resp_data_p1;
    assign resp1_data  = resp_data_p1;

endmodule

// File: tb/tb_pkt_buf_rd_arbiter.sv
// Directed bench for pkt_buf_rd_arbiter with a fixed-latency buffer model and
// issue/response monitors.
module tb_pkt_buf_rd_arbiter;

    localparam int AW = 12;
    localparam int DW = 520;
    localparam int MO = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req0_valid = 1'b0, req0_last = 1'b0, req0_ready;
    logic [AW-1:0] req0_addr = '0;
    logic          req1_valid = 1'b0, req1_last = 1'b0, req1_ready;
    logic [AW-1:0] req1_addr = '0;
    logic          rd_valid;
    logic [AW-1:0] rd_addr;
    logic          rd_resp_valid;
    logic [DW-1:0] rd_resp_data;
    logic          resp0_valid, resp1_valid;
    logic [DW-1:0] resp0_data, resp1_data;
    logic [CW-1:0] outstanding;
    logic          err_orphan_resp;
    logic [31:0]   stats_grant0, stats_grant1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic          auto_mode = 1'b0;
    int            lat = 1;
    logic          man_v = 1'b0;
    logic [DW-1:0] man_data = '0;
    logic          pipe_v [0:7];
    logic [AW-1:0] pipe_a [0:7];

    int            iss_id [$];
    logic [AW-1:0] iss_addr [$];
    int            iss_cyc [$];
    int            rsp_id [$];
    logic [DW-1:0] rsp_data [$];
    int            rsp_cyc [$];

    pkt_buf_rd_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_last(req1_last), .req1_ready(req1_ready),
        .rd_valid(rd_valid), .rd_addr(rd_addr),
        .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
        .resp0_valid(resp0_valid), .resp0_data(resp0_data),
        .resp1_valid(resp1_valid), .resp1_data(resp1_data),
        .outstanding(outstanding), .err_orphan_resp(err_orphan_resp),
        .stats_grant0(stats_grant0), .stats_grant1(stats_grant1)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mkdata(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        d = DW'(a);
        return (d << (DW - AW)) | d;
    endfunction

    // Fixed-latency packet buffer: a flit issued in cycle t returns in cycle t+lat.
    always @(posedge clk) begin
        pipe_v[0] <= rd_valid;
        pipe_a[0] <= rd_addr;
        for (int i = 1; i < 8; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_a[i] <= pipe_a[i-1];
        end
        cyc <= cyc + 1;
    end

    assign rd_resp_valid = auto_mode ? pipe_v[lat-1] : man_v;
    assign rd_resp_data  = auto_mode ? mkdata(pipe_a[lat-1]) : man_data;

    always @(negedge clk) begin
        if (rd_valid) begin
            iss_id.push_back(req1_ready ? 1 : 0);
            iss_addr.push_back(rd_addr);
            iss_cyc.push_back(cyc);
        end
        if (resp0_valid) begin
            rsp_id.push_back(0);
            rsp_data.push_back(resp0_data);
            rsp_cyc.push_back(cyc);
        end
        if (resp1_valid) begin
            rsp_id.push_back(1);
            rsp_data.push_back(resp1_data);
            rsp_cyc.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        iss_id.delete(); iss_addr.delete(); iss_cyc.delete();
        rsp_id.delete(); rsp_data.delete(); rsp_cyc.delete();
    endtask

    task automatic do_reset();
        req0_valid = 1'b0; req1_valid = 1'b0; req0_last = 1'b0; req1_last = 1'b0;
        man_v = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic burst(input int id, input logic [AW-1:0] base, input int n);
        int   beat = 0;
        int   guard = 0;
        logic acc;
        while (beat < n && guard < 100) begin
            if (id == 0) begin
                req0_valid = 1'b1; req0_addr = base + AW'(beat); req0_last = (beat == n - 1);
            end else begin
                req1_valid = 1'b1; req1_addr = base + AW'(beat); req1_last = (beat == n - 1);
            end
            #1;
            acc = (id == 0) ? req0_ready : req1_ready;
            step();
            if (acc) beat++;
            guard++;
        end
        if (id == 0) req0_valid = 1'b0;
        else         req1_valid = 1'b0;
        checks++;
        if (beat != n) begin
            failures++;
            $display("FAIL burst%0d_timeout beats=%0d required=%0d", id, beat, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_addr = 12'h5A5; req0_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({req0_ready, req1_ready, rd_valid, resp0_valid, resp1_valid, err_orphan_resp} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b required=000000",
                     {req0_ready, req1_ready, rd_valid, resp0_valid, resp1_valid, err_orphan_resp});
        end
        checks++;
        if (rd_addr !== '0 || outstanding !== '0) begin
            failures++;
            $display("FAIL reset_addr_outstanding got=%h/%0d required=0/0", rd_addr, outstanding);
        end
        checks++;
        if (stats_grant0 !== 32'd0 || stats_grant1 !== 32'd0 || resp0_data !== '0 || resp1_data !== '0) begin
            failures++;
            $display("FAIL reset_stats_data got=%0d/%0d required=0/0", stats_grant0, stats_grant1);
        end
        req0_valid = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        do_reset();
        auto_mode = 1'b1; lat = 3;
        clear_q();
        burst(0, 12'h010, 4);
        repeat (8) step();
        checks++;
        if (iss_id.size() != 4 || rsp_id.size() != 4) begin
            failures++;
            $display("FAIL single_counts issues=%0d resps=%0d required=4/4", iss_id.size(), rsp_id.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (iss_addr[i] !== 12'h010 + AW'(i) || iss_cyc[i] != iss_cyc[0] + i) begin
                    failures++;
                    $display("FAIL single_issue%0d addr=%h cyc=%0d required=%h/%0d",
                             i, iss_addr[i], iss_cyc[i], 12'h010 + AW'(i), iss_cyc[0] + i);
                end
                checks++;
                if (rsp_id[i] != 0 || rsp_data[i] !== mkdata(12'h010 + AW'(i)) || rsp_cyc[i] != iss_cyc[i] + 4) begin
                    failures++;
                    $display("FAIL single_resp%0d id=%0d dlow=%h cyc=%0d required=0/%h/%0d",
                             i, rsp_id[i], rsp_data[i][AW-1:0], rsp_cyc[i], 12'h010 + AW'(i), iss_cyc[i] + 4);
                end
            end
        end
        checks++;
        if (stats_grant0 !== 32'd1 || outstanding !== '0) begin
            failures++;
            $display("FAIL single_stats got=%0d/%0d required=1/0", stats_grant0, outstanding);
        end
    endtask

    task automatic test_contention();
        logic [AW-1:0] exp_a [12];
        int            exp_i [12];
        for (int i = 0; i < 12; i++) begin
            exp_i[i] = (i / 3) % 2;
            exp_a[i] = 12'h020 + AW'((i / 3) * 16 + (i % 3));
        end
        do_reset();
        auto_mode = 1'b1; lat = 1;
        clear_q();
        fork
            begin burst(0, 12'h020, 3); burst(0, 12'h040, 3); end
            begin burst(1, 12'h030, 3); burst(1, 12'h050, 3); end
        join
        repeat (4) step();
        checks++;
        if (iss_id.size() != 12) begin
            failures++;
            $display("FAIL contention_count got=%0d required=12", iss_id.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                checks++;
                if (iss_id[i] != exp_i[i] || iss_addr[i] !== exp_a[i]) begin
                    failures++;
                    $display("FAIL contention_beat%0d id=%0d addr=%h required=%0d/%h",
                             i, iss_id[i], iss_addr[i], exp_i[i], exp_a[i]);
                end
            end
        end
        checks++;
        if (stats_grant0 !== 32'd2 || stats_grant1 !== 32'd2) begin
            failures++;
            $display("FAIL contention_stats got=%0d/%0d required=2/2", stats_grant0, stats_grant1);
        end
    endtask

    task automatic test_credit();
        int k = 0;
        do_reset();
        auto_mode = 1'b0;
        clear_q();
        req0_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            req0_addr = 12'h100 + AW'(k); req0_last = (k == 11);
            #1;
            if (req0_ready) k++;
            step();
        end
        req0_addr = 12'h100 + AW'(k); req0_last = (k == 11);
        #1;
        checks++;
        if (k != 8 || req0_ready !== 1'b0 || outstanding !== 4'd8) begin
            failures++;
            $display("FAIL credit_full issued=%0d ready=%b outstanding=%0d required=8/0/8", k, req0_ready, outstanding);
        end
        for (int r = 0; r < 4; r++) begin
            man_v = 1'b1; man_data = mkdata(12'h700 + AW'(r));
            #1;
            checks++;
            if (req0_ready !== 1'b1) begin
                failures++;
                $display("FAIL credit_release%0d ready=%b required=1", r, req0_ready);
            end
            step();
            if (req0_ready || k < 12) k++;
            man_v = 1'b0;
            if (k == 12) req0_valid = 1'b0;
            req0_addr = 12'h100 + AW'(k); req0_last = (k == 11);
            #1;
            checks++;
            if (req0_ready !== 1'b0 || outstanding !== 4'd8) begin
                failures++;
                $display("FAIL credit_hold%0d ready=%b outstanding=%0d required=0/8", r, req0_ready, outstanding);
            end
        end
        man_v = 1'b1;
        repeat (8) step();
        man_v = 1'b0;
        repeat (3) step();
        checks++;
        if (outstanding !== '0 || err_orphan_resp !== 1'b0 || stats_grant0 !== 32'd1) begin
            failures++;
            $display("FAIL credit_drain outstanding=%0d err=%b stats0=%0d required=0/0/1",
                     outstanding, err_orphan_resp, stats_grant0);
        end
        checks++;
        if (iss_id.size() != 12 || rsp_id.size() != 12) begin
            failures++;
            $display("FAIL credit_totals issues=%0d resps=%0d required=12/12", iss_id.size(), rsp_id.size());
        end
    endtask

    task automatic test_lock_hold();
        do_reset();
        auto_mode = 1'b1; lat = 1;
        req0_valid = 1'b1; req0_addr = 12'h060; req0_last = 1'b0;
        req1_valid = 1'b1; req1_addr = 12'h070; req1_last = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL lock_first ready0=%b ready1=%b required=1/0", req0_ready, req1_ready);
        end
        step();
        req0_addr = 12'h061;
        step();
        req0_valid = 1'b0;
        for (int g = 0; g < 5; g++) begin
            #1;
            checks++;
            if (req1_ready !== 1'b0 || rd_valid !== 1'b0) begin
                failures++;
                $display("FAIL lock_gap%0d ready1=%b rd_valid=%b required=0/0", g, req1_ready, rd_valid);
            end
            step();
        end
        req0_valid = 1'b1; req0_addr = 12'h062; req0_last = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL lock_last ready0=%b ready1=%b required=1/0", req0_ready, req1_ready);
        end
        step();
        req0_valid = 1'b0;
        #1;
        checks++;
        if (req1_ready !== 1'b1 || rd_addr !== 12'h070) begin
            failures++;
            $display("FAIL lock_handover ready1=%b addr=%h required=1/070", req1_ready, rd_addr);
        end
        step();
        req1_valid = 1'b0;
        checks++;
        if (stats_grant0 !== 32'd1 || stats_grant1 !== 32'd1) begin
            failures++;
            $display("FAIL lock_stats got=%0d/%0d required=1/1", stats_grant0, stats_grant1);
        end
        repeat (3) step();
    endtask

    task automatic test_routing();
        logic [AW-1:0] exp_a [5];
        int            exp_i [5];
        exp_a[0] = 12'h080; exp_a[1] = 12'h081; exp_a[2] = 12'h090; exp_a[3] = 12'h0A0; exp_a[4] = 12'h0A1;
        exp_i[0] = 0; exp_i[1] = 0; exp_i[2] = 1; exp_i[3] = 0; exp_i[4] = 0;
        do_reset();
        auto_mode = 1'b1; lat = 1;
        clear_q();
        burst(0, 12'h080, 2);
        burst(1, 12'h090, 1);
        burst(0, 12'h0A0, 2);
        repeat (5) step();
        checks++;
        if (rsp_id.size() != 5) begin
            failures++;
            $display("FAIL routing_count got=%0d required=5", rsp_id.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (rsp_id[i] != exp_i[i] || rsp_data[i] !== mkdata(exp_a[i])) begin
                    failures++;
                    $display("FAIL routing_resp%0d id=%0d dlow=%h required=%0d/%h",
                             i, rsp_id[i], rsp_data[i][AW-1:0], exp_i[i], exp_a[i]);
                end
            end
        end
        checks++;
        if (outstanding !== '0) begin
            failures++;
            $display("FAIL routing_outstanding got=%0d required=0", outstanding);
        end
    endtask

    task automatic test_orphan_reset();
        do_reset();
        auto_mode = 1'b0;
        clear_q();
        man_v = 1'b1; man_data = mkdata(12'h3C3);
        step();
        man_v = 1'b0;
        #1;
        checks++;
        if (err_orphan_resp !== 1'b1 || outstanding !== '0) begin
            failures++;
            $display("FAIL orphan_flag err=%b outstanding=%0d required=1/0", err_orphan_resp, outstanding);
        end
        repeat (2) step();
        checks++;
        if (rsp_id.size() != 0 || err_orphan_resp !== 1'b1) begin
            failures++;
            $display("FAIL orphan_sticky resps=%0d err=%b required=0/1", rsp_id.size(), err_orphan_resp);
        end
        req0_valid = 1'b1; req0_addr = 12'h0B0; req0_last = 1'b0;
        step();
        req0_addr = 12'h0B1;
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req0_ready, req1_ready, rd_valid, resp0_valid, resp1_valid, err_orphan_resp} !== 6'b0 ||
            rd_addr !== '0 || outstanding !== '0 || stats_grant0 !== 32'd0) begin
            failures++;
            $display("FAIL midburst_reset flags=%b addr=%h outstanding=%0d required=000000/000/0",
                     {req0_ready, req1_ready, rd_valid, resp0_valid, resp1_valid, err_orphan_resp},
                     rd_addr, outstanding);
        end
        step();
        req0_valid = 1'b0;
        rst_n = 1'b1;
        step();
        man_v = 1'b1;
        step();
        man_v = 1'b0;
        #1;
        checks++;
        if (err_orphan_resp !== 1'b1 || outstanding !== '0 || rsp_id.size() != 0) begin
            failures++;
            $display("FAIL post_reset_orphan err=%b outstanding=%0d resps=%0d required=1/0/0",
                     err_orphan_resp, outstanding, rsp_id.size());
        end
        req1_valid = 1'b1; req1_addr = 12'h0C0; req1_last = 1'b1;
        #1;
        checks++;
        if (req1_ready !== 1'b1 || rd_addr !== 12'h0C0) begin
            failures++;
            $display("FAIL post_reset_idle ready1=%b addr=%h required=1/0C0", req1_ready, rd_addr);
        end
        step();
        req1_valid = 1'b0;
        repeat (2) step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_credit();
        test_lock_hold();
        test_routing();
        test_orphan_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout time=%0t required=finish", $time);
        $fatal(1, "timeout");
    end

endmodule
